// File: rtl/if_id_if.sv
// IF->ID pipeline bus: fetch-side inputs and decode-side outputs of the IF/ID register.
// The stage uses the slave modport; the pipeline around it uses master.
interface if_id_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  logic [INSTR_W-1:0] instruction_IF;
  logic [PC_W-1:0]    PC_sumado_IF;
  logic               valid_IF;
  logic               ready_IF;
  logic [INSTR_W-1:0] instruction_ID;
  logic [PC_W-1:0]    PC_sumado_ID;
  logic               valid_ID;
  logic               ready_ID;

  modport master (
    output instruction_IF, PC_sumado_IF, valid_IF, ready_ID,
    input  ready_IF, instruction_ID, PC_sumado_ID, valid_ID
  );

  modport slave (
    input  instruction_IF, PC_sumado_IF, valid_IF, ready_ID,
    output ready_IF, instruction_ID, PC_sumado_ID, valid_ID
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so ready_IF can be a flop.
// Also counts ID stall cycles and flushes that squashed live entries.
module if_id_stage #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  if_id_if.slave           bus,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           main_q, main_d, skid_q, skid_d, in_entry;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             accept, consume;

  assign in_entry = '{instr: bus.instruction_IF, pc: bus.PC_sumado_IF};
  assign accept   = bus.valid_IF & ready_q;
  assign consume  = main_valid_q & bus.ready_ID;

  always_comb begin
    // NOTE: every signal gets a hold default before any branch so no path leaves it unassigned (no latch).
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if ((main_valid_q || skid_valid_q) && flush_cnt_q != CNT_MAX)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      if (consume) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = accept;
          if (accept) skid_d = in_entry;
        end else if (accept) begin
          main_d = in_entry;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        // ready_q implies the skid is empty, so a held main spills into skid
        if (main_valid_q) begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end else begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end
      end

      if (main_valid_q && !bus.ready_ID && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      // NOTE: the data registers are reset too because PC_sumado_ID must read 0 after reset.
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.ready_IF       = ready_q;
  assign bus.valid_ID       = main_valid_q;
  assign bus.instruction_ID = main_valid_q ? main_q.instr : NOP_INSTR;
  assign bus.PC_sumado_ID   = main_q.pc;
  assign stall_count        = stall_cnt_q;
  assign flush_count        = flush_cnt_q;

endmodule
